// File: rtl/pe_operand_collector_if.sv
// ---------------------------------------------------------------------------
// pe_operand_collector_if
//   Bundles every handshake and bus signal of the operand collector. Clock
//   and reset are not in this bundle.
//
//   Instruction channel : inst_fn, inst_dest, inst_use_op3, inst_valid -> ;
//                         inst_ready <-
//   Operand channels    : opN_data, opN_valid -> ; opN_req <-   (N = 1..3)
//   Compute unit side   : cmp_operandN, cmp_operandN_v, cmp_operandN_req,
//                         cmp_fn <- ; cmp_result, cmp_done ->
//   Write-back channel  : wb_data, wb_dest, wb_valid <- ; wb_ready ->
//   Status              : busy <-
//
//   Modports
//     master : the collector itself (drives the "<-" signals above)
//     slave  : the environment (instruction source, operand sources,
//              compute unit and write-back consumer)
// ---------------------------------------------------------------------------
interface pe_operand_collector_if #(
  parameter int DATA_LEN   = 32,
  parameter int LOG_NUM_FN = 3,
  parameter int DEST_LEN   = 4
);
  logic [LOG_NUM_FN-1:0] inst_fn;
  logic [DEST_LEN-1:0]   inst_dest;
  logic                  inst_use_op3;
  logic                  inst_valid;
  logic                  inst_ready;

  logic [DATA_LEN-1:0]   op1_data, op2_data, op3_data;
  logic                  op1_valid, op2_valid, op3_valid;
  logic                  op1_req, op2_req, op3_req;

  logic [DATA_LEN-1:0]   cmp_operand1, cmp_operand2, cmp_operand3;
  logic                  cmp_operand1_v, cmp_operand2_v, cmp_operand3_v;
  logic                  cmp_operand1_req, cmp_operand2_req, cmp_operand3_req;
  logic [LOG_NUM_FN-1:0] cmp_fn;
  logic [DATA_LEN-1:0]   cmp_result;
  logic                  cmp_done;

  logic [DATA_LEN-1:0]   wb_data;
  logic [DEST_LEN-1:0]   wb_dest;
  logic                  wb_valid;
  logic                  wb_ready;

  logic                  busy;

  modport master (
    input  inst_fn, inst_dest, inst_use_op3, inst_valid,
    output inst_ready,
    input  op1_data, op2_data, op3_data, op1_valid, op2_valid, op3_valid,
    output op1_req, op2_req, op3_req,
    output cmp_operand1, cmp_operand2, cmp_operand3,
    output cmp_operand1_v, cmp_operand2_v, cmp_operand3_v,
    output cmp_operand1_req, cmp_operand2_req, cmp_operand3_req,
    output cmp_fn,
    input  cmp_result, cmp_done,
    output wb_data, wb_dest, wb_valid,
    input  wb_ready,
    output busy
  );

  modport slave (
    output inst_fn, inst_dest, inst_use_op3, inst_valid,
    input  inst_ready,
    output op1_data, op2_data, op3_data, op1_valid, op2_valid, op3_valid,
    input  op1_req, op2_req, op3_req,
    input  cmp_operand1, cmp_operand2, cmp_operand3,
    input  cmp_operand1_v, cmp_operand2_v, cmp_operand3_v,
    input  cmp_operand1_req, cmp_operand2_req, cmp_operand3_req,
    input  cmp_fn,
    output cmp_result, cmp_done,
    input  wb_data, wb_dest, wb_valid,
    output wb_ready,
    input  busy
  );
endinterface

// File: rtl/pe_operand_collector.sv
// ---------------------------------------------------------------------------
// pe_operand_collector
//   Issue-side front end of a PE compute unit. Accepts one instruction at a
//   time, collects its two or three operands in any order from independent
//   valid/req channels, presents them to the combinational compute unit,
//   registers the result and offers it on a write-back channel with
//   backpressure.
//
//   Ports
//     clk   : rising-edge clock
//     reset : asynchronous, active-low reset
//     bus   : pe_operand_collector_if.master (instruction, operand, compute
//             unit, write-back and busy signals)
//
//   inst_ready and opN_req are decoded from the state register; every other
//   output comes straight from a flop.
// ---------------------------------------------------------------------------
module pe_operand_collector #(
  parameter int DATA_LEN   = 32,
  parameter int LOG_NUM_FN = 3,
  parameter int DEST_LEN   = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  pe_operand_collector_if.master        bus
);

  typedef enum logic [1:0] {IDLE, COLLECT, ISSUE, WB} state_t;

  state_t                state_q, state_d;
  logic [LOG_NUM_FN-1:0] fn_q, fn_d;
  logic [DEST_LEN-1:0]   dest_q, dest_d;
  logic                  use_op3_q, use_op3_d;
  logic [2:0]            got_q, got_d;

  logic [2:0]            need;
  logic [2:0]            op_valid;
  logic [2:0]            op_req;
  logic [2:0]            cap;
  logic [DATA_LEN-1:0]   op_data  [3];
  logic [DATA_LEN-1:0]   op_q     [3];
  logic [DATA_LEN-1:0]   op_d     [3];
  logic [DATA_LEN-1:0]   cmp_op_q [3];

  logic [2:0]            cmp_v_q, cmp_r_q;
  logic [LOG_NUM_FN-1:0] cmp_fn_q;
  logic [DATA_LEN-1:0]   wb_data_q;
  logic [DEST_LEN-1:0]   wb_dest_q;
  logic                  wb_valid_q;
  logic                  busy_q;
  logic                  enter_issue;

  // Channel signals gathered into index-able vectors (bit 0 = operand 1).
  assign op_valid   = {bus.op3_valid, bus.op2_valid, bus.op1_valid};
  assign op_data[0] = bus.op1_data;
  assign op_data[1] = bus.op2_data;
  assign op_data[2] = bus.op3_data;

  assign need   = {use_op3_q, 2'b11};
  // Request only what is still missing, and only while collecting.
  assign op_req = (state_q == COLLECT) ? (need & ~got_q) : 3'b000;
  assign cap    = op_req & op_valid;

  assign enter_issue = (state_q == COLLECT) && (state_d == ISSUE);

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    fn_d      = fn_q;
    dest_d    = dest_q;
    use_op3_d = use_op3_q;
    got_d     = got_q;
    case (state_q)
      IDLE: begin
        if (bus.inst_valid) begin
          fn_d      = bus.inst_fn;
          dest_d    = bus.inst_dest;
          use_op3_d = bus.inst_use_op3;
          got_d     = 3'b000;
          state_d   = COLLECT;
        end
      end
      COLLECT: begin
        got_d = got_q | cap;
        // Move on in the cycle the last missing operand lands.
        if ((got_d & need) == need) begin
          state_d = ISSUE;
        end
      end
      ISSUE: begin
        if (bus.cmp_done) begin
          state_d = WB;
        end
      end
      WB: begin
        // wb_valid is always high in WB, so wb_ready alone completes it.
        if (bus.wb_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // -------------------------------------------------------------------------
  // Control and output registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      fn_q       <= '0;
      dest_q     <= '0;
      use_op3_q  <= 1'b0;
      got_q      <= 3'b000;
      cmp_v_q    <= 3'b000;
      cmp_r_q    <= 3'b000;
      cmp_fn_q   <= '0;
      wb_data_q  <= '0;
      wb_dest_q  <= '0;
      wb_valid_q <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      fn_q       <= fn_d;
      dest_q     <= dest_d;
      use_op3_q  <= use_op3_d;
      got_q      <= got_d;
      // Strobes are high exactly while the next state is ISSUE.
      cmp_v_q    <= (state_d == ISSUE) ? got_d : 3'b000;
      cmp_r_q    <= (state_d == ISSUE) ? need  : 3'b000;
      if (enter_issue) begin
        cmp_fn_q <= fn_q;
      end
      if ((state_q == ISSUE) && bus.cmp_done) begin
        wb_data_q <= bus.cmp_result;
        wb_dest_q <= dest_q;
      end
      wb_valid_q <= (state_d == WB);
      busy_q     <= (state_d != IDLE);
    end
  end

  // -------------------------------------------------------------------------
  // Per-channel operand latches and compute-unit operand registers.
  // cmp_operandN is loaded on entry to ISSUE from op_d so an operand captured
  // in that same cycle is already included; it then holds until the next
  // issue.
  // -------------------------------------------------------------------------
  for (genvar gi = 0; gi < 3; gi++) begin : g_chan
    assign op_d[gi] = cap[gi] ? op_data[gi] : op_q[gi];

    always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
        op_q[gi]     <= '0;
        cmp_op_q[gi] <= '0;
      end else begin
        op_q[gi] <= op_d[gi];
        if (enter_issue) begin
          cmp_op_q[gi] <= op_d[gi];
        end
      end
    end
  end

  // -------------------------------------------------------------------------
  // Output mapping
  // -------------------------------------------------------------------------
  assign bus.inst_ready       = (state_q == IDLE);
  assign bus.op1_req          = op_req[0];
  assign bus.op2_req          = op_req[1];
  assign bus.op3_req          = op_req[2];
  assign bus.cmp_operand1     = cmp_op_q[0];
  assign bus.cmp_operand2     = cmp_op_q[1];
  assign bus.cmp_operand3     = cmp_op_q[2];
  assign bus.cmp_operand1_v   = cmp_v_q[0];
  assign bus.cmp_operand2_v   = cmp_v_q[1];
  assign bus.cmp_operand3_v   = cmp_v_q[2];
  assign bus.cmp_operand1_req = cmp_r_q[0];
  assign bus.cmp_operand2_req = cmp_r_q[1];
  assign bus.cmp_operand3_req = cmp_r_q[2];
  assign bus.cmp_fn           = cmp_fn_q;
  assign bus.wb_data          = wb_data_q;
  assign bus.wb_dest          = wb_dest_q;
  assign bus.wb_valid         = wb_valid_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_pe_operand_collector.sv
// ---------------------------------------------------------------------------
// tb_pe_operand_collector
//   Table-driven bench for pe_operand_collector, plus a hand-written
//   mid-collection reset sequence. A small behavioural compute unit answers
//   the collector's issue; expected write-back values are fixed constants.
// ---------------------------------------------------------------------------
module tb_pe_operand_collector;
  localparam int DATA_LEN   = 32;
  localparam int LOG_NUM_FN = 3;
  localparam int DEST_LEN   = 4;

  localparam logic [2:0] FN_ADD = 3'd0;
  localparam logic [2:0] FN_SUB = 3'd1;
  localparam logic [2:0] FN_MUL = 3'd2;
  localparam logic [2:0] FN_COM = 3'd3;
  localparam logic [2:0] FN_FMA = 3'd4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_bad;

  pe_operand_collector_if #(
    .DATA_LEN(DATA_LEN), .LOG_NUM_FN(LOG_NUM_FN), .DEST_LEN(DEST_LEN)
  ) bus_if ();

  pe_operand_collector #(
    .DATA_LEN(DATA_LEN), .LOG_NUM_FN(LOG_NUM_FN), .DEST_LEN(DEST_LEN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural compute unit: done once every required operand is valid.
  logic signed [31:0] ca, cb, cc;
  logic [2:0]         creq, cval;
  always_comb begin
    ca   = bus_if.cmp_operand1;
    cb   = bus_if.cmp_operand2;
    cc   = bus_if.cmp_operand3;
    creq = {bus_if.cmp_operand3_req, bus_if.cmp_operand2_req, bus_if.cmp_operand1_req};
    cval = {bus_if.cmp_operand3_v, bus_if.cmp_operand2_v, bus_if.cmp_operand1_v};
    bus_if.cmp_result = '0;
    case (bus_if.cmp_fn)
      FN_ADD:  bus_if.cmp_result = ca + cb;
      FN_SUB:  bus_if.cmp_result = ca - cb;
      FN_MUL:  bus_if.cmp_result = ca * cb;
      FN_COM:  bus_if.cmp_result = {31'd0, (ca > cb)};
      FN_FMA:  bus_if.cmp_result = ca * cb + cc;
      default: bus_if.cmp_result = '0;
    endcase
    bus_if.cmp_done = (|creq) && ((cval | ~creq) == 3'b111);
  end

  typedef struct {
    logic [2:0]  fn;
    logic [3:0]  dest;
    logic        use3;
    logic [31:0] o1, o2, o3;
    int          d1, d2, d3;   // cycle (after acceptance) each operand turns valid
    int          hold;         // cycles wb_ready stays low once wb_valid is up
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    bus_if.inst_valid = 1'b0;
    bus_if.op1_valid  = 1'b0;
    bus_if.op2_valid  = 1'b0;
    bus_if.op3_valid  = 1'b0;
    bus_if.wb_ready   = 1'b0;
  endtask

  task automatic run_vec(input int i);
    vec_t v;
    int   maxd, wbc, last;
    string tag;
    v    = vecs[i];
    maxd = (v.d1 > v.d2) ? v.d1 : v.d2;
    if (v.use3 && v.d3 > maxd) maxd = v.d3;
    wbc  = maxd + 2;
    last = wbc + v.hold;

    @(negedge clk);
    chk($sformatf("v%0d c0 inst_ready", i), 32'(bus_if.inst_ready), 32'd1);
    chk($sformatf("v%0d c0 busy", i), 32'(bus_if.busy), 32'd0);
    bus_if.inst_fn      = v.fn;
    bus_if.inst_dest    = v.dest;
    bus_if.inst_use_op3 = v.use3;
    bus_if.inst_valid   = 1'b1;

    for (int c = 1; c <= last; c++) begin
      @(negedge clk);
      tag = $sformatf("v%0d c%0d", i, c);
      chk({tag, " op1_req"}, 32'(bus_if.op1_req), 32'(c <= v.d1));
      chk({tag, " op2_req"}, 32'(bus_if.op2_req), 32'(c <= v.d2));
      chk({tag, " op3_req"}, 32'(bus_if.op3_req), 32'(v.use3 && c <= v.d3));
      chk({tag, " inst_ready"}, 32'(bus_if.inst_ready), 32'd0);
      chk({tag, " busy"}, 32'(bus_if.busy), 32'd1);
      chk({tag, " cmp1_v"}, 32'(bus_if.cmp_operand1_v), 32'(c == maxd + 1));
      chk({tag, " cmp3_v"}, 32'(bus_if.cmp_operand3_v), 32'(v.use3 && c == maxd + 1));
      chk({tag, " cmp3_req"}, 32'(bus_if.cmp_operand3_req), 32'(v.use3 && c == maxd + 1));
      if (c == maxd + 1) begin
        chk({tag, " cmp_fn"}, 32'(bus_if.cmp_fn), 32'(v.fn));
        chk({tag, " cmp_op1"}, bus_if.cmp_operand1, v.o1);
        chk({tag, " cmp_op2"}, bus_if.cmp_operand2, v.o2);
        if (v.use3) chk({tag, " cmp_op3"}, bus_if.cmp_operand3, v.o3);
      end
      chk({tag, " wb_valid"}, 32'(bus_if.wb_valid), 32'(c >= wbc));
      if (c >= wbc) begin
        chk({tag, " wb_data"}, bus_if.wb_data, v.exp);
        chk({tag, " wb_dest"}, 32'(bus_if.wb_dest), 32'(v.dest));
      end
      // Scrambled instruction fields after acceptance; a competing
      // instruction is offered while the result waits for wb_ready.
      bus_if.inst_fn    = 3'd7;
      bus_if.inst_dest  = 4'hF;
      bus_if.inst_valid = (c >= wbc) && (c < last);
      // Operand valid stays up after its slot with junk data, which must be
      // ignored once captured (or if the channel is not needed at all).
      bus_if.op1_valid  = (c >= v.d1);
      bus_if.op1_data   = (c == v.d1) ? v.o1 : 32'hDEAD_0001;
      bus_if.op2_valid  = (c >= v.d2);
      bus_if.op2_data   = (c == v.d2) ? v.o2 : 32'hDEAD_0002;
      bus_if.op3_valid  = (c >= v.d3);
      bus_if.op3_data   = (c == v.d3) ? v.o3 : 32'hDEAD_0003;
      bus_if.wb_ready   = (c == last);
    end

    @(negedge clk);
    chk($sformatf("v%0d post wb_valid", i), 32'(bus_if.wb_valid), 32'd0);
    chk($sformatf("v%0d post busy", i), 32'(bus_if.busy), 32'd0);
    chk($sformatf("v%0d post inst_ready", i), 32'(bus_if.inst_ready), 32'd1);
    $display("vector %0d: fn=%0d dest=%0d wb_data=%h (expected %h)",
             i, v.fn, v.dest, bus_if.wb_data, v.exp);
    idle_inputs();
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    //            fn      dest  use3 o1            o2         o3     d1 d2 d3 hold exp
    vecs[0] = '{FN_ADD, 4'd5,  1'b0, 32'd12,       32'd9,     32'd0, 1, 1, 1, 0, 32'd21};
    vecs[1] = '{FN_MUL, 4'd2,  1'b0, 32'hFFFFFFFD, 32'd7,     32'd0, 4, 1, 1, 0, 32'hFFFFFFEB};
    vecs[2] = '{FN_COM, 4'd7,  1'b0, 32'd15,       32'd8,     32'd0, 1, 2, 1, 0, 32'd1};
    vecs[3] = '{FN_COM, 4'd8,  1'b0, 32'd8,        32'd15,    32'd0, 2, 1, 1, 0, 32'd0};
    vecs[4] = '{FN_SUB, 4'd9,  1'b0, 32'd9,        32'd14,    32'd0, 1, 1, 1, 5, 32'hFFFFFFFB};
    vecs[5] = '{FN_FMA, 4'd10, 1'b1, 32'd3,        32'd4,     32'd5, 2, 3, 1, 0, 32'd17};

    bus_if.inst_fn      = '0;
    bus_if.inst_dest    = '0;
    bus_if.inst_use_op3 = 1'b0;
    bus_if.op1_data     = '0;
    bus_if.op2_data     = '0;
    bus_if.op3_data     = '0;
    idle_inputs();

    reset = 1'b0;
    #1;
    chk("reset inst_ready", 32'(bus_if.inst_ready), 32'd1);
    chk("reset busy", 32'(bus_if.busy), 32'd0);
    chk("reset wb_valid", 32'(bus_if.wb_valid), 32'd0);
    chk("reset op1_req", 32'(bus_if.op1_req), 32'd0);
    chk("reset cmp1_v", 32'(bus_if.cmp_operand1_v), 32'd0);
    chk("reset wb_data", bus_if.wb_data, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    for (int i = 0; i < 6; i++) run_vec(i);

    // Reset in the middle of collection, after op1 has been captured.
    @(negedge clk);
    bus_if.inst_fn      = FN_ADD;
    bus_if.inst_dest    = 4'd3;
    bus_if.inst_use_op3 = 1'b0;
    bus_if.inst_valid   = 1'b1;
    @(negedge clk);
    bus_if.inst_valid = 1'b0;
    bus_if.op1_valid  = 1'b1;
    bus_if.op1_data   = 32'd100;
    @(negedge clk);
    bus_if.op1_valid = 1'b0;
    chk("rst-seq op1_req after capture", 32'(bus_if.op1_req), 32'd0);
    chk("rst-seq op2_req pending", 32'(bus_if.op2_req), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    chk("rst-seq inst_ready", 32'(bus_if.inst_ready), 32'd1);
    chk("rst-seq busy", 32'(bus_if.busy), 32'd0);
    chk("rst-seq op2_req", 32'(bus_if.op2_req), 32'd0);
    chk("rst-seq wb_valid", 32'(bus_if.wb_valid), 32'd0);
    chk("rst-seq wb_data", bus_if.wb_data, 32'd0);
    chk("rst-seq cmp_op1", bus_if.cmp_operand1, 32'd0);
    chk("rst-seq cmp_fn", 32'(bus_if.cmp_fn), 32'd0);
    @(negedge clk);
    reset = 1'b1;
    $display("mid-collect reset applied and released");
    // The next instruction must request op1 again from scratch.
    run_vec(0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
